// File: rtl/qtcore_scan_master_if.sv
// Host-side bus of the qtcore scan master: image buffer access, exchange/run
// control and the scan/processor pins toward the qtcore.
interface qtcore_scan_master_if #(
  parameter int CNT_W = 16
);
  logic             load_valid_in;
  logic [7:0]       load_data_in;
  logic             rd_ack_in;
  logic [7:0]       rd_data_out;
  logic             start_xchg_in;
  logic             start_run_in;
  logic [CNT_W-1:0] run_max_in;
  logic             scan_en_n_out;
  logic             proc_en_n_out;
  logic             scan_d_out;
  logic             scan_q_in;
  logic             busy_out;
  logic             done_out;
  logic             halted_out;
  logic [CNT_W-1:0] run_cycles_out;

  modport master (
    input  load_valid_in, load_data_in, rd_ack_in, start_xchg_in,
           start_run_in, run_max_in, scan_q_in,
    output rd_data_out, scan_en_n_out, proc_en_n_out, scan_d_out,
           busy_out, done_out, halted_out, run_cycles_out
  );

  modport slave (
    output load_valid_in, load_data_in, rd_ack_in, start_xchg_in,
           start_run_in, run_max_in, scan_q_in,
    input  rd_data_out, scan_en_n_out, proc_en_n_out, scan_d_out,
           busy_out, done_out, halted_out, run_cycles_out
  );
endinterface

// File: rtl/qtcore_scan_master.sv
// Scan-chain master for a qtcore: byte-wide image buffer, full-chain exchange
// and bounded run-until-halt with cycle count.
//
// state | meaning
// IDLE  | image buffer accessible by bytes, waiting for a start
// SHIFT | CHAIN_LEN edges swapping image and qtcore chain, scan_en_n low
// RUN   | proc_en_n low, counting cycles until halt or run_max
module qtcore_scan_master #(
  parameter int CHAIN_LEN = 160,
  parameter int CNT_W     = 16
) (
  input logic clk_in,
  input logic rst_in,
  qtcore_scan_master_if.master bus
);
  localparam int BIT_W = $clog2(CHAIN_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]           state;
  logic [CHAIN_LEN-1:0] image;
  logic [BIT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     run_cnt;
  logic [CNT_W-1:0]     run_max;
  logic [CNT_W-1:0]     run_next;
  logic                 done;
  logic                 halted;
  logic                 hit_halt;

  assign run_next = run_cnt + CNT_W'(1);
  // scan_q doubles as the halt flag once the core has had two cycles to settle
  assign hit_halt = (run_next >= CNT_W'(2)) && bus.scan_q_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= ST_IDLE;
      image   <= '0;
      bit_cnt <= '0;
      run_cnt <= '0;
      run_max <= '0;
      done    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_xchg_in) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end else if (bus.start_run_in) begin
            run_max <= bus.run_max_in;
            run_cnt <= '0;
            halted  <= 1'b0;
            if (bus.run_max_in == '0) done  <= 1'b1;
            else                      state <= ST_RUN;
          end else if (bus.load_valid_in) begin
            image <= {image[CHAIN_LEN-9:0], bus.load_data_in};
          end else if (bus.rd_ack_in) begin
            image <= {image[CHAIN_LEN-9:0], image[CHAIN_LEN-1 -: 8]};
          end
        end
        ST_SHIFT: begin
          image   <= {image[CHAIN_LEN-2:0], bus.scan_q_in};
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        ST_RUN: begin
          run_cnt <= run_next;
          if (hit_halt) begin
            halted <= 1'b1;
            state  <= ST_IDLE;
            done   <= 1'b1;
          end else if (run_next == run_max) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.scan_en_n_out  = (state != ST_SHIFT);
  assign bus.proc_en_n_out  = (state != ST_RUN);
  assign bus.busy_out       = (state != ST_IDLE);
  assign bus.done_out       = done;
  assign bus.halted_out     = halted;
  assign bus.run_cycles_out = run_cnt;
  assign bus.scan_d_out     = image[CHAIN_LEN-1];
  assign bus.rd_data_out    = image[CHAIN_LEN-1 -: 8];
endmodule
